// File: rtl/switch_pio_rx.sv
// Debounced slide-switch input port with a 4-register read/write slave (DATA, SYNC, IRQMASK, EDGE).
// Latency: switch to DATA is 2 sync cycles + DEBOUNCE_CYCLES; read data follows avs_read by exactly 1 cycle.
// Backpressure: none; every read and write is accepted on the cycle it is strobed. Optional irq via SWITCH_PIO_IRQ_EN.
module switch_pio_rx #(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [WIDTH-1:0] slide_pio_external_export,
   input  logic [1:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             avs_readdatavalid,
   output logic             irq
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] deb_q, deb_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] rd_mux;
   logic [31:0]      rd_dat_q;
   logic             rd_vld_q;

   // Two-flop synchronizer on the raw switch levels
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= slide_pio_external_export;
         sync2_q <= sync1_q;
      end
   end

   // Per-bit debounce: count consecutive mismatch cycles, any agreement restarts from zero
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_TERM) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Debounced bits and their counters
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         deb_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // EDGE: write-1-to-clear, but a fresh edge in the same cycle wins over the clear
   always_comb begin
      edge_clr = '0;
      if (avs_write && (avs_address == 2'd3)) begin
         edge_clr = avs_writedata[WIDTH-1:0];
      end
      edge_d = (edge_q & ~edge_clr) | (deb_d ^ deb_q);
   end

   // EDGE register
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         edge_q <= '0;
      end else begin
         edge_q <= edge_d;
      end
   end

`ifdef SWITCH_PIO_IRQ_EN
   logic [WIDTH-1:0] mask_q;
   logic             irq_q;

   // Interrupt mask, writable at address 2
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         mask_q <= '0;
      end else if (avs_write && (avs_address == 2'd2)) begin
         mask_q <= avs_writedata[WIDTH-1:0];
      end
   end

   // Registered level interrupt from the current EDGE and mask contents
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(edge_q & mask_q);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   // Register read select; reads see the pre-write value when read and write coincide
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         2'd0: rd_mux = deb_q;
         2'd1: rd_mux = sync2_q;
`ifdef SWITCH_PIO_IRQ_EN
         2'd2: rd_mux = mask_q;
`else
         2'd2: rd_mux = '0;
`endif
         default: rd_mux = edge_q;
      endcase
   end

   // One-cycle read response; data bus held at zero when not valid
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rd_vld_q <= 1'b0;
         rd_dat_q <= '0;
      end else begin
         rd_vld_q <= avs_read;
         rd_dat_q <= avs_read ? 32'(rd_mux) : 32'd0;
      end
   end

   assign avs_readdata      = rd_dat_q;
   assign avs_readdatavalid = rd_vld_q;

   // Write data above WIDTH carries no register bits
   if (WIDTH < 32) begin : g_unused_wd
      logic unused_wd;
      assign unused_wd = ^avs_writedata[31:WIDTH];
   end

endmodule

// File: tb/tb_switch_pio_rx.sv
// Bench for switch_pio_rx (WIDTH=10, DEBOUNCE_CYCLES=4), default build or SWITCH_PIO_IRQ_EN.
// Register vector table, hand-written multi-cycle sequences, then random traffic against a reference model.
module tb_switch_pio_rx;

   localparam int W   = 10;
   localparam int DEB = 4;
`ifdef SWITCH_PIO_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  sw = '0;
   logic [1:0]    addr = '0;
   logic          rd = 1'b0;
   logic          wr = 1'b0;
   logic [31:0]   wd = '0;
   logic [31:0]   rdata;
   logic          rvld;
   logic          irq;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   switch_pio_rx #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk_clk                   (clk),
      .reset_reset_n             (rst_n),
      .slide_pio_external_export (sw),
      .avs_address               (addr),
      .avs_read                  (rd),
      .avs_write                 (wr),
      .avs_writedata             (wd),
      .avs_readdata              (rdata),
      .avs_readdatavalid         (rvld),
      .irq                       (irq)
   );

   // Reference model: raw switches delayed two cycles, a bit flips once the last DEB
   // synchronized samples all disagree with it.
   logic [W-1:0] m_s1, m_s2, m_deb, m_edge, m_mask;
   logic [W-1:0] m_hist[$];
   logic         m_irq;
   logic         m_vld;
   logic [31:0]  m_dat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_edge = '0; m_mask = '0;
      m_hist.delete();
      m_irq = 1'b0; m_vld = 1'b0; m_dat = '0;
   endtask

   task automatic model_step(input logic [W-1:0] c_sw, input logic [1:0] c_addr, input logic c_rd,
                             input logic c_wr, input logic [31:0] c_wd);
      logic [W-1:0] val, chg, old;
      bit all_differ;
      case (c_addr)
         2'd0: val = m_deb;
         2'd1: val = m_s2;
         2'd2: val = m_mask;
         default: val = m_edge;
      endcase
      m_vld = c_rd;
      m_dat = c_rd ? 32'(val) : 32'd0;
      m_irq = IRQ_EN && (|(m_edge & m_mask));
      m_hist.push_back(m_s2);
      if (m_hist.size() > DEB) old = m_hist.pop_front();
      chg = '0;
      if (m_hist.size() == DEB) begin
         for (int b = 0; b < W; b++) begin
            all_differ = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][b] == m_deb[b]) all_differ = 1'b0;
            chg[b] = all_differ;
         end
      end
      m_deb = m_deb ^ chg;
      if (c_wr && c_addr == 2'd3) m_edge = m_edge & ~c_wd[W-1:0];
      m_edge = m_edge | chg;
      if (IRQ_EN && c_wr && c_addr == 2'd2) m_mask = c_wd[W-1:0];
      m_s2 = m_s1;
      m_s1 = c_sw;
   endtask

   // One clock: model consumes the inputs the DUT samples, then outputs are compared
   task automatic tick();
      logic [W-1:0] c_sw;
      logic [1:0]   c_addr;
      logic         c_rd, c_wr, c_rst;
      logic [31:0]  c_wd;
      c_sw = sw; c_addr = addr; c_rd = rd; c_wr = wr; c_wd = wd; c_rst = rst_n;
      @(posedge clk);
      #1;
      if (!c_rst) model_reset();
      else model_step(c_sw, c_addr, c_rd, c_wr, c_wd);
      chk("model_vld", 32'(rvld), 32'(m_vld));
      chk("model_dat", rdata, m_dat);
      chk("model_irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic cycle(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
      rd = r; wr = w; addr = a; wd = d;
      tick();
      rd = 1'b0; wr = 1'b0;
   endtask

   task automatic assert_reset(input logic with_read);
      rst_n = 1'b0;
      rd = with_read; addr = 2'd1;
      model_reset();
      #1;
      chk("rst_dat", rdata, 32'd0);
      chk("rst_vld", 32'(rvld), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      tick();
      rd = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        r;
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      logic        exp_vld;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t tbl[9];

   initial begin
      tbl[0] = '{1'b0, 1'b1, 2'd0, 32'h0000_03FF, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b1, 32'h0};
      tbl[2] = '{1'b1, 1'b1, 2'd1, 32'h0000_0FFF, 1'b1, 32'h0};
      tbl[3] = '{1'b0, 1'b1, 2'd2, 32'hFFFF_F404, 1'b0, 32'h0};
      tbl[4] = '{1'b1, 1'b0, 2'd2, 32'h0,         1'b1, IRQ_EN ? 32'h4 : 32'h0};
      tbl[5] = '{1'b1, 1'b1, 2'd2, 32'h0,         1'b1, IRQ_EN ? 32'h4 : 32'h0};
      tbl[6] = '{1'b1, 1'b0, 2'd2, 32'h0,         1'b1, 32'h0};
      tbl[7] = '{1'b1, 1'b0, 2'd3, 32'h0,         1'b1, 32'h0};
      tbl[8] = '{1'b0, 1'b1, 2'd3, 32'h0000_03FF, 1'b0, 32'h0};

      model_reset();
      #2;
      assert_reset(1'b0);

      // register map on an idle port
      foreach (tbl[i]) begin
         cycle(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
         chk($sformatf("tbl%0d_vld", i), 32'(rvld), 32'(tbl[i].exp_vld));
         chk($sformatf("tbl%0d_dat", i), rdata, tbl[i].exp_dat);
      end

      // three-cycle glitch on bit 3 never reaches DATA or EDGE
      sw = 10'h008; ticks(3);
      sw = 10'h000; ticks(8);
      cycle(1'b1, 1'b0, 2'd0, 0); chk("glitch_data", rdata, 32'h0);
      cycle(1'b1, 1'b0, 2'd3, 0); chk("glitch_edge", rdata, 32'h0);

      // 0x000 -> 0x005: DATA changes exactly 2+4 cycles later
      sw = 10'h005; ticks(5);
      cycle(1'b1, 1'b0, 2'd0, 0); chk("deb_early", rdata, 32'h0);
      cycle(1'b1, 1'b0, 2'd0, 0); chk("deb_data", rdata, 32'h5);
      cycle(1'b1, 1'b0, 2'd3, 0); chk("deb_edge", rdata, 32'h5);

      // write-1-to-clear, then a clear colliding with a new bit-0 edge
      cycle(1'b0, 1'b1, 2'd3, 32'h1);
      cycle(1'b1, 1'b0, 2'd3, 0); chk("w1c_edge", rdata, 32'h4);
      sw = 10'h004; ticks(5);
      cycle(1'b0, 1'b1, 2'd3, 32'h1);
      cycle(1'b1, 1'b0, 2'd3, 0); chk("w1c_collide", rdata, 32'h5);
      cycle(1'b1, 1'b0, 2'd0, 0); chk("w1c_data", rdata, 32'h4);

      // interrupt from a masked bit-2 edge
      cycle(1'b0, 1'b1, 2'd3, 32'h3FF);
      cycle(1'b0, 1'b1, 2'd2, 32'h4);
      sw = 10'h000; ticks(6);
      chk("irq_pre", 32'(irq), 32'd0);
      tick();
      chk("irq_set", 32'(irq), 32'(IRQ_EN));
      cycle(1'b0, 1'b1, 2'd3, 32'h4);
      chk("irq_hold", 32'(irq), 32'(IRQ_EN));
      tick();
      chk("irq_clr", 32'(irq), 32'd0);
      cycle(1'b1, 1'b0, 2'd2, 0); chk("mask_rd", rdata, IRQ_EN ? 32'h4 : 32'h0);

      // SYNC read: one-cycle valid pulse
      sw = 10'h2A1; ticks(3);
      cycle(1'b1, 1'b0, 2'd1, 0);
      chk("sync_vld", 32'(rvld), 32'd1);
      chk("sync_dat", rdata, 32'h2A1);
      tick();
      chk("sync_vld_drop", 32'(rvld), 32'd0);
      chk("sync_dat_zero", rdata, 32'd0);

      // reset mid-debounce with a read in the reset cycle; count restarts after release
      ticks(8);
      sw = 10'h0F0; ticks(4);
      assert_reset(1'b1);
      chk("rst_read_drop", 32'(rvld), 32'd0);
      ticks(5);
      cycle(1'b1, 1'b0, 2'd0, 0); chk("rst_deb_early", rdata, 32'h0);
      cycle(1'b1, 1'b0, 2'd0, 0); chk("rst_deb_data", rdata, 32'h0F0);
      cycle(1'b1, 1'b0, 2'd3, 0); chk("rst_deb_edge", rdata, 32'h0F0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(5) == 0) sw = W'($urandom);
         rd   = 1'($urandom_range(1));
         wr   = ($urandom_range(3) == 0);
         addr = 2'($urandom_range(3));
         wd   = $urandom;
         tick();
      end
      rd = 1'b0; wr = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/switch_pio_rx.md
SWITCH_PIO_RX -- requirements
Module: switch_pio_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 10: number of slide-switch inputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable cycles before a debounced bit changes (1 ms at 50 MHz); legal range 2..2^20.
REQ-003 SHALL have port clk_clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port reset_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port slide_pio_external_export, input, WIDTH bits: raw asynchronous switch levels.
REQ-006 SHALL have port avs_address, input, 2 bits: register select.
REQ-007 SHALL have port avs_read, input, 1 bit: read strobe.
REQ-008 SHALL have port avs_write, input, 1 bit: write strobe.
REQ-009 SHALL have port avs_writedata, input, 32 bits: write data.
REQ-010 SHALL have port avs_readdata, output, 32 bits: read data.
REQ-011 SHALL have port avs_readdatavalid, output, 1 bit: read data qualifier.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt (REQ-031).

Function
REQ-013 SHALL pass each input bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL keep one debounce counter per bit, ceil(log2(DEBOUNCE_CYCLES)) bits wide.
REQ-015 SHALL clear a bit's counter on any cycle where its synchronized value equals its debounced value.
REQ-016 SHALL otherwise increment the counter; on the cycle it reaches DEBOUNCE_CYCLES-1, copy the synchronized value into the debounced bit and clear the counter.
REQ-017 SHALL restart the count from zero when the input glitches back before terminal count; no partial credit.
REQ-018 SHALL use register map: 0 = DATA (debounced bits, read-only); 1 = SYNC (synchronized raw bits, read-only); 2 = IRQMASK (read/write); 3 = EDGE (read, write-1-to-clear).
REQ-019 SHALL set EDGE bit n on the cycle debounced bit n changes, rising or falling.
REQ-020 SHALL, when a write-1-to-clear and a new edge hit the same EDGE bit in one cycle, leave the bit set.
REQ-021 SHALL respond to reads with fixed latency 1: avs_readdata valid and avs_readdatavalid high exactly the cycle after avs_read.
REQ-022 SHALL zero-extend all WIDTH-bit fields to 32 bits; writedata bits above WIDTH are ignored.
REQ-023 SHALL drive avs_readdata to 0 on cycles where avs_readdatavalid is low.
REQ-024 SHALL ignore writes to addresses 0 and 1.
REQ-025 SHALL give read priority when avs_read and avs_write are asserted together, and perform the write as well.
REQ-026 SHALL leave EDGE unchanged on a read of EDGE; clearing occurs only by write.

Reset
REQ-027 SHALL, while reset_reset_n is low, asynchronously force synchronizers, debounced bits, counters, EDGE, IRQMASK, avs_readdata, avs_readdatavalid and irq to 0.
REQ-028 SHALL discard a read issued in the cycle reset asserts; no avs_readdatavalid follows.
REQ-029 SHALL, after reset release with switches high, raise DATA bits only after full debounce and set the matching EDGE bits.

Configuration
REQ-030 SHALL use macro SWITCH_PIO_IRQ_EN to compile the interrupt logic in or out.
REQ-031 SHALL, with SWITCH_PIO_IRQ_EN defined, register irq = OR of (EDGE AND IRQMASK), one cycle after EDGE/IRQMASK update.
REQ-032 SHALL, without SWITCH_PIO_IRQ_EN, tie irq to 0, omit the IRQMASK storage, read address 2 as 0, and ignore writes to it.

Verification (bench uses WIDTH=10, DEBOUNCE_CYCLES=4)
REQ-033 SHALL cover: switches 0x000 -> 0x005 held -> DATA reads 0x005 exactly 2+4 cycles after the change; EDGE = 0x005.
REQ-034 SHALL cover: bit 3 pulses high for 3 cycles then returns -> DATA and EDGE stay 0x000.
REQ-035 SHALL cover: EDGE = 0x005, write 0x001 to address 3 -> EDGE reads 0x004; write coinciding with a new bit-0 edge -> bit 0 stays 1.
REQ-036 SHALL cover (IRQ_EN): IRQMASK = 0x004, bit 2 edge -> irq high one cycle after EDGE sets; write 0x004 to EDGE -> irq low next cycle; without macro irq stays 0.
REQ-037 SHALL cover: read of address 1 -> avs_readdatavalid high for exactly 1 cycle, one cycle after avs_read, data = synchronized switches.
REQ-038 SHALL cover: reset asserted mid-debounce (count 2) -> all outputs 0 immediately; count restarts from 0 after release.
